// File: rtl/spatz_pkg.sv
// Shared Spatz types and sizing for the memory-port arbiter and its requesters.
package spatz_pkg;

    localparam int unsigned NrMemArbReq       = 2;
    localparam int unsigned MemArbOutstanding = 8;

    typedef logic [$clog2(NrMemArbReq)-1:0] mem_arb_idx_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } spatz_mem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } spatz_mem_resp_t;

endpackage

// File: rtl/fifo_v3.sv
// Generic synchronous FIFO, registered output, one cycle push-to-pop latency.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two >= 2.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q[ADDR_DEPTH-1:0];
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + ADDR_DEPTH'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_DEPTH'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + (ADDR_DEPTH+1)'(1);
        end else if (pop_ok && !push_ok) begin
            cnt_d = cnt_q - (ADDR_DEPTH+1)'(1);
        end
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spatz_mem_arbiter.sv
// Round-robin share of one memory port among NrReq requesters; zero-cycle grant, grant held while stalled.
// Responses return in order and are steered by a tag FIFO; a full FIFO blocks new grants.
module spatz_mem_arbiter
    import spatz_pkg::*;
#(
    parameter int unsigned NrReq          = NrMemArbReq,
    parameter int unsigned NumOutstanding = MemArbOutstanding,
    parameter type         mem_req_t      = spatz_mem_req_t,
    parameter type         mem_resp_t     = spatz_mem_resp_t,
    parameter int unsigned IdxWidth       = $clog2(NrReq)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  mem_req_t  [NrReq-1:0]             req_i,
    input  logic      [NrReq-1:0]             req_valid_i,
    output logic      [NrReq-1:0]             req_ready_o,
    output mem_resp_t [NrReq-1:0]             resp_o,
    output logic      [NrReq-1:0]             resp_valid_o,
    input  logic      [NrReq-1:0]             resp_ready_i,
    output mem_req_t                          mem_req_o,
    output logic                              mem_req_valid_o,
    input  logic                              mem_req_ready_i,
    input  mem_resp_t                         mem_resp_i,
    input  logic                              mem_resp_valid_i,
    output logic                              mem_resp_ready_o,
    output logic [$clog2(NumOutstanding):0]   outstanding_o,
    output logic                              busy_o
);

    logic [IdxWidth-1:0] rr_ptr_q, rr_ptr_d;
    logic                lock_q, lock_d;
    logic [IdxWidth-1:0] locked_idx_q, locked_idx_d;

    logic [IdxWidth-1:0] winner;
    logic [IdxWidth:0]   cand;
    logic                found;
    logic                accept, stall, pop;
    logic                fifo_full, fifo_empty;
    logic [IdxWidth-1:0] head_idx;
    logic [$clog2(NumOutstanding)-1:0] fifo_usage;
    logic                rst_n;

    // Search starts at rr_ptr and wraps; an active lock overrides the search.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        cand   = '0;
        for (int i = 0; i < NrReq; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxWidth+1)'(i);
            if (cand >= (IdxWidth+1)'(NrReq)) begin
                cand = cand - (IdxWidth+1)'(NrReq);
            end
            if (!found && req_valid_i[cand[IdxWidth-1:0]]) begin
                winner = cand[IdxWidth-1:0];
                found  = 1'b1;
            end
        end
        if (lock_q) begin
            winner = locked_idx_q;
        end
    end

    always_comb begin
        mem_req_o       = req_i[winner];
        mem_req_valid_o = !rst_i && req_valid_i[winner] && !fifo_full;
        req_ready_o     = '0;
        req_ready_o[winner] = !rst_i && mem_req_ready_i && !fifo_full;

        resp_valid_o           = '0;
        resp_valid_o[head_idx] = !rst_i && mem_resp_valid_i && !fifo_empty;
        mem_resp_ready_o       = !rst_i && resp_ready_i[head_idx] && !fifo_empty;
        for (int i = 0; i < NrReq; i++) begin
            resp_o[i] = mem_resp_i;
        end
    end

    assign accept = mem_req_valid_o && mem_req_ready_i;
    assign stall  = mem_req_valid_o && !mem_req_ready_i;
    assign pop    = mem_resp_valid_i && mem_resp_ready_o;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        locked_idx_d = locked_idx_q;
        if (accept) begin
            rr_ptr_d = (winner == IdxWidth'(NrReq - 1)) ? '0 : winner + IdxWidth'(1);
            lock_d   = 1'b0;
        end else if (stall) begin
            lock_d       = 1'b1;
            locked_idx_d = winner;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            locked_idx_q <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            locked_idx_q <= locked_idx_d;
        end
    end

    assign rst_n = ~rst_i;

    fifo_v3 #(
        .DATA_WIDTH (IdxWidth),
        .DEPTH      (NumOutstanding)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_n),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (winner),
        .push_i  (accept),
        .data_o  (head_idx),
        .pop_i   (pop)
    );

    // Usage wraps to zero when full, so the full flag supplies the MSB.
    assign outstanding_o = {fifo_full, fifo_usage};
    assign busy_o        = (outstanding_o != '0) || (|req_valid_i);

`ifndef SYNTHESIS
    a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i)
        !(mem_resp_valid_i && fifo_empty));
    a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        stall |=> (mem_req_valid_o && (mem_req_o == $past(mem_req_o))));
    a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        outstanding_o <= ($clog2(NumOutstanding)+1)'(NumOutstanding));
`endif

endmodule

// File: tb/tb_spatz_mem_arbiter.sv
// Directed bench for spatz_mem_arbiter with two requesters and an 8-deep tag FIFO.
module tb_spatz_mem_arbiter;
    import spatz_pkg::*;

    logic                  clk_i = 1'b0;
    logic                  rst_i;
    spatz_mem_req_t  [1:0] req_i;
    logic            [1:0] req_valid_i;
    logic            [1:0] req_ready_o;
    spatz_mem_resp_t [1:0] resp_o;
    logic            [1:0] resp_valid_o;
    logic            [1:0] resp_ready_i;
    spatz_mem_req_t        mem_req_o;
    logic                  mem_req_valid_o;
    logic                  mem_req_ready_i;
    spatz_mem_resp_t       mem_resp_i;
    logic                  mem_resp_valid_i;
    logic                  mem_resp_ready_o;
    logic [3:0]            outstanding_o;
    logic                  busy_o;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A0 = 32'h1000_0040;
    localparam logic [31:0] A1 = 32'h2000_0080;

    spatz_mem_arbiter dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .req_i            (req_i),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .resp_o           (resp_o),
        .resp_valid_o     (resp_valid_o),
        .resp_ready_i     (resp_ready_i),
        .mem_req_o        (mem_req_o),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_resp_i       (mem_resp_i),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_ready_o (mem_resp_ready_o),
        .outstanding_o    (outstanding_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i            = 1'b1;
        req_i[0]         = '{addr: A0, write: 1'b0, strb: 4'hf, wdata: 32'h0000_0000};
        req_i[1]         = '{addr: A1, write: 1'b1, strb: 4'h3, wdata: 32'h5555_aaaa};
        req_valid_i      = 2'b11;
        mem_req_ready_i  = 1'b1;
        mem_resp_i       = '{rdata: 32'hdead_beef, err: 1'b0};
        mem_resp_valid_i = 1'b0;
        resp_ready_i     = 2'b11;

        // Outputs are gated off while reset is held, even with requests pending.
        #2;
        check("rst_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        tick();
        rst_i = 1'b0;

        // Both requesters valid, port always ready: alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_addr", 64'(mem_req_o.addr), (k % 2) ? 64'(A1) : 64'(A0));
            check("rr_ready", 64'(req_ready_o), (k % 2) ? 64'd2 : 64'd1);
            check("rr_valid", 64'(mem_req_valid_o), 64'd1);
            tick();
        end
        req_valid_i = 2'b00;
        #1;
        check("rr_outstanding", 64'(outstanding_o), 64'd4);
        check("rr_idle_valid", 64'(mem_req_valid_o), 64'd0);
        mem_resp_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_resp_route", 64'(resp_valid_o), (k % 2) ? 64'd2 : 64'd1);
            check("rr_resp_ready", 64'(mem_resp_ready_o), 64'd1);
            if (k == 1) check("rr_resp_data", 64'(resp_o[1].rdata), 64'hdead_beef);
            tick();
        end
        mem_resp_valid_i = 1'b0;
        #1;
        check("drain_outstanding", 64'(outstanding_o), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);

        // Requester 1 stalls three cycles; requester 0 joins but the lock holds.
        req_valid_i     = 2'b10;
        mem_req_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_valid", 64'(mem_req_valid_o), 64'd1);
            check("stall_addr", 64'(mem_req_o.addr), 64'(A1));
            check("stall_ready", 64'(req_ready_o), 64'd0);
            check("stall_busy", 64'(busy_o), 64'd1);
            tick();
        end
        req_valid_i = 2'b11;
        #1;
        check("lock_addr", 64'(mem_req_o.addr), 64'(A1));
        check("lock_ready", 64'(req_ready_o), 64'd0);
        tick();
        mem_req_ready_i = 1'b1;
        #1;
        check("unstall_addr", 64'(mem_req_o.addr), 64'(A1));
        check("unstall_ready", 64'(req_ready_o), 64'd2);
        tick();
        check("after_lock_addr", 64'(mem_req_o.addr), 64'(A0));
        check("after_lock_ready", 64'(req_ready_o), 64'd1);
        req_valid_i      = 2'b00;
        mem_resp_valid_i = 1'b1;
        #1;
        check("lock_resp_route", 64'(resp_valid_o), 64'd2);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        check("lock_outstanding", 64'(outstanding_o), 64'd0);

        // Fill all eight tags from requester 0 alone.
        req_valid_i = 2'b01;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fill_ready", 64'(req_ready_o), 64'd1);
            tick();
        end
        #1;
        check("full_outstanding", 64'(outstanding_o), 64'd8);
        check("full_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("full_req_ready", 64'(req_ready_o), 64'd0);
        mem_resp_valid_i = 1'b1;
        #1;
        check("full_pop_route", 64'(resp_valid_o), 64'd1);
        check("full_pop_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("full_pop_req_ready", 64'(req_ready_o), 64'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        check("after_pop_outstanding", 64'(outstanding_o), 64'd7);
        check("after_pop_mem_valid", 64'(mem_req_valid_o), 64'd1);
        check("after_pop_ready", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i      = 2'b00;
        mem_resp_valid_i = 1'b1;
        #1;
        check("refill_outstanding", 64'(outstanding_o), 64'd8);
        for (int k = 0; k < 8; k++) begin
            #1;
            check("full_drain_route", 64'(resp_valid_o), 64'd1);
            tick();
        end
        mem_resp_valid_i = 1'b0;
        #1;
        check("full_drain_outstanding", 64'(outstanding_o), 64'd0);

        // Tags 0 then 1; requester 0 withholds response ready for two cycles.
        req_valid_i = 2'b01;
        #1;
        check("bp_push0", 64'(req_ready_o), 64'd1);
        tick();
        req_valid_i = 2'b10;
        #1;
        check("bp_push1", 64'(req_ready_o), 64'd2);
        tick();
        req_valid_i      = 2'b00;
        mem_resp_valid_i = 1'b1;
        resp_ready_i     = 2'b10;
        for (int k = 0; k < 2; k++) begin
            #1;
            check("bp_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
            check("bp_route", 64'(resp_valid_o), 64'd1);
            tick();
        end
        resp_ready_i = 2'b11;
        #1;
        check("bp_release_ready", 64'(mem_resp_ready_o), 64'd1);
        check("bp_release_route", 64'(resp_valid_o), 64'd1);
        tick();
        check("bp_second_route", 64'(resp_valid_o), 64'd2);
        check("bp_second_ready", 64'(mem_resp_ready_o), 64'd1);
        tick();
        mem_resp_valid_i = 1'b0;
        #1;
        check("bp_outstanding", 64'(outstanding_o), 64'd0);

        // Tags 0,1,0 then a cycle that pushes and pops together.
        req_valid_i = 2'b11;
        for (int k = 0; k < 3; k++) tick();
        mem_resp_valid_i = 1'b1;
        #1;
        check("pp_before_count", 64'(outstanding_o), 64'd3);
        check("pp_before_head", 64'(resp_valid_o), 64'd1);
        check("pp_before_grant", 64'(req_ready_o), 64'd2);
        tick();
        check("pp_after_count", 64'(outstanding_o), 64'd3);
        check("pp_after_head", 64'(resp_valid_o), 64'd2);
        req_valid_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("pp_drain_route", 64'(resp_valid_o), (k == 1) ? 64'd1 : 64'd2);
            tick();
        end
        mem_resp_valid_i = 1'b0;

        // Five tags in flight, then an asynchronous reset discards them.
        req_valid_i = 2'b11;
        for (int k = 0; k < 5; k++) tick();
        check("prerst_outstanding", 64'(outstanding_o), 64'd5);
        rst_i            = 1'b1;
        mem_resp_valid_i = 1'b1;
        #1;
        check("midrst_outstanding", 64'(outstanding_o), 64'd0);
        check("midrst_mem_valid", 64'(mem_req_valid_o), 64'd0);
        check("midrst_req_ready", 64'(req_ready_o), 64'd0);
        check("midrst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("midrst_mem_resp_ready", 64'(mem_resp_ready_o), 64'd0);
        tick();
        mem_resp_valid_i = 1'b0;
        rst_i            = 1'b0;
        #1;
        check("postrst_ready", 64'(req_ready_o), 64'd1);
        check("postrst_addr", 64'(mem_req_o.addr), 64'(A0));
        check("postrst_outstanding", 64'(outstanding_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
